// File: rtl/fence_pkg.sv
// Shared types for the fence unit: the fence kind produced by the fence decoder.
package fence_pkg;

  typedef enum logic [1:0] {
    fk_fence   = 2'd0,
    fk_fence_i = 2'd1,
    fk_invalid = 2'd2
  } fence_kind_t;

endpackage

// File: rtl/fence_unit_if.sv
// Request bus between decode/issue and the fence unit.
//   req_valid  master->slave  request valid
//   req_ready  slave->master  unit can accept a request
//   req_kind   master->slave  fence kind (fk_fence / fk_fence_i / fk_invalid)
//   req_pc     master->slave  pc of the fence instruction
interface fence_unit_if #(
  parameter int XLEN = 32
);
  import fence_pkg::*;

  logic              req_valid;
  logic              req_ready;
  fence_kind_t       req_kind;
  logic [XLEN-1:0]   req_pc;

  modport master (
    output req_valid,
    output req_kind,
    output req_pc,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_kind,
    input  req_pc,
    output req_ready
  );

endinterface

// File: rtl/fence_unit.sv
// FENCE / FENCE.I execution unit. Stalls issue until outstanding memory ops
// retire and the store buffer drains; for FENCE.I it then invalidates the
// I-cache and redirects fetch to pc+4.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req               fence request bus (slave side)
//   mem_issue_i       LSU issued one memory op this cycle
//   mem_complete_i    LSU retired one memory op this cycle
//   sb_empty_i        store buffer empty
//   ic_inv_req_o      I-cache invalidate-all request
//   ic_inv_ack_i      I-cache invalidate complete
//   flush_valid_o     pipeline flush + fetch redirect pulse
//   flush_pc_o        redirect target (0 when flush_valid_o is low)
//   done_o            fence retired pulse
//   illegal_o         fk_invalid accepted pulse
//   busy_o            unit not idle
//   overflow_o        sticky: memory op issued at max outstanding count
//
// state | meaning
// IDLE  | ready for a request
// DRAIN | waiting for outstanding ops and store buffer to empty
// INV   | I-cache invalidate requested, waiting for ack
// FLUSH | one-cycle flush/redirect and retire of FENCE.I
module fence_unit
  import fence_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  fence_unit_if.slave     req,
  input  logic            mem_issue_i,
  input  logic            mem_complete_i,
  input  logic            sb_empty_i,
  output logic            ic_inv_req_o,
  input  logic            ic_inv_ack_i,
  output logic            flush_valid_o,
  output logic [XLEN-1:0] flush_pc_o,
  output logic            done_o,
  output logic            illegal_o,
  output logic            busy_o,
  output logic            overflow_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    INV   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  fence_kind_t       kind_q, kind_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic              flush_valid_q, flush_valid_d;
  logic [XLEN-1:0]   flush_pc_q, flush_pc_d;
  logic              ic_inv_req_q, ic_inv_req_d;
  logic              drained;

  // Outstanding-op counter, active in every state.
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (mem_issue_i && !mem_complete_i) begin
      if (count_q == CNT_MAX) overflow_d = 1'b1;
      else                    count_d    = count_q + 1'b1;
    end else if (mem_complete_i && !mem_issue_i) begin
      if (count_q != '0) count_d = count_q - 1'b1;
    end
  end

  // An issue in the same cycle would make the registered count stale.
  assign drained = (count_q == '0) && sb_empty_i && !mem_issue_i;

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    pc_d          = pc_q;
    done_d        = 1'b0;
    illegal_d     = 1'b0;
    flush_valid_d = 1'b0;
    flush_pc_d    = '0;
    ic_inv_req_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          kind_d = req.req_kind;
          pc_d   = req.req_pc;
          if (req.req_kind == fk_fence || req.req_kind == fk_fence_i) state_d = DRAIN;
          else                                                        illegal_d = 1'b1;
        end
      end
      DRAIN: begin
        if (drained) begin
          if (kind_q == fk_fence_i) begin
            state_d      = INV;
            ic_inv_req_d = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      INV: begin
        if (ic_inv_ack_i) begin
          state_d       = FLUSH;
          flush_valid_d = 1'b1;
          done_d        = 1'b1;
          flush_pc_d    = pc_q + XLEN'(4);
        end else begin
          ic_inv_req_d = 1'b1;
        end
      end
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      kind_q        <= fk_fence;
      pc_q          <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
      flush_valid_q <= 1'b0;
      flush_pc_q    <= '0;
      ic_inv_req_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      pc_q          <= pc_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      done_q        <= done_d;
      illegal_q     <= illegal_d;
      flush_valid_q <= flush_valid_d;
      flush_pc_q    <= flush_pc_d;
      ic_inv_req_q  <= ic_inv_req_d;
    end
  end

  assign req.req_ready  = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;
  assign illegal_o      = illegal_q;
  assign flush_valid_o  = flush_valid_q;
  assign flush_pc_o     = flush_pc_q;
  assign ic_inv_req_o   = ic_inv_req_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_fence_unit.sv
// Directed testbench for fence_unit.
module tb_fence_unit;
  import fence_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_issue, mem_complete, sb_empty;
  logic        ic_inv_req, ic_inv_ack;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic        done, illegal, busy, overflow;

  int n_checks = 0;
  int n_fail   = 0;

  fence_unit_if #(.XLEN(32)) req_if ();

  fence_unit #(.XLEN(32), .CNT_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req_if),
    .mem_issue_i    (mem_issue),
    .mem_complete_i (mem_complete),
    .sb_empty_i     (sb_empty),
    .ic_inv_req_o   (ic_inv_req),
    .ic_inv_ack_i   (ic_inv_ack),
    .flush_valid_o  (flush_valid),
    .flush_pc_o     (flush_pc),
    .done_o         (done),
    .illegal_o      (illegal),
    .busy_o         (busy),
    .overflow_o     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input fence_kind_t kind, input logic [31:0] pc);
    req_if.req_valid = 1'b1;
    req_if.req_kind  = kind;
    req_if.req_pc    = pc;
    step();
    req_if.req_valid = 1'b0;
  endtask

  task automatic wait_busy(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      check_eq({tag, "_busy"}, busy, 1);
      check_eq({tag, "_done"}, done, 0);
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    req_if.req_valid = 1'b0;
    req_if.req_kind  = fk_fence;
    req_if.req_pc    = '0;
    mem_issue        = 1'b0;
    mem_complete     = 1'b0;
    sb_empty         = 1'b1;
    ic_inv_ack       = 1'b0;
    #3;
    check_eq("rst_ready", req_if.req_ready, 1);
    check_eq("rst_outs", {done, illegal, flush_valid, ic_inv_req, busy, overflow}, 0);
    check_eq("rst_flush_pc", flush_pc, 0);
    check_eq("rst_count", dut.count_q, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Plain fence, idle LSU, then back-to-back fence in the done cycle.
    send(fk_fence, 32'h0000_0040);
    check_eq("f1_busy", busy, 1);
    check_eq("f1_done_early", done, 0);
    check_eq("f1_ready", req_if.req_ready, 0);
    step();
    check_eq("f1_done", done, 1);
    check_eq("f1_busy_done", busy, 0);
    check_eq("f1_inv", ic_inv_req, 0);
    check_eq("f1_flush", flush_valid, 0);
    send(fk_fence, 32'h0000_0044);
    check_eq("b2b_busy", busy, 1);
    check_eq("b2b_done_pulse", done, 0);
    step();
    check_eq("b2b_done", done, 1);
    step();
    check_eq("b2b_done_end", done, 0);

    // Fence with outstanding ops and a busy store buffer.
    mem_issue = 1'b1;
    repeat (3) step();
    mem_issue = 1'b0;
    check_eq("f2_count3", dut.count_q, 3);
    sb_empty = 1'b0;
    send(fk_fence, 32'h0000_0080);
    check_eq("f2_busy0", busy, 1);
    wait_busy(3, "f2_w1");
    mem_complete = 1'b1;
    step();
    mem_complete = 1'b0;
    check_eq("f2_count2", dut.count_q, 2);
    check_eq("f2_busy_c1", busy, 1);
    mem_issue = 1'b1; mem_complete = 1'b1;
    step();
    mem_issue = 1'b0; mem_complete = 1'b0;
    check_eq("f2_both", dut.count_q, 2);
    wait_busy(2, "f2_w2");
    mem_complete = 1'b1;
    step();
    mem_complete = 1'b0;
    check_eq("f2_count1", dut.count_q, 1);
    wait_busy(3, "f2_w3");
    mem_complete = 1'b1;
    step();
    mem_complete = 1'b0;
    check_eq("f2_count0", dut.count_q, 0);
    wait_busy(3, "f2_sb");
    sb_empty = 1'b1;
    step();
    check_eq("f2_done", done, 1);
    check_eq("f2_busy_done", busy, 0);

    // FENCE.I with ack delayed 5 cycles.
    send(fk_fence_i, 32'h0000_1000);
    check_eq("fi_drain_inv", ic_inv_req, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      check_eq("fi_inv_req", ic_inv_req, 1);
      check_eq("fi_flush_low", {flush_valid, done}, 0);
      check_eq("fi_pc_low", flush_pc, 0);
      if (i == 4) ic_inv_ack = 1'b1;
      step();
    end
    ic_inv_ack = 1'b0;
    check_eq("fi_flush_valid", flush_valid, 1);
    check_eq("fi_flush_pc", flush_pc, 32'h0000_1004);
    check_eq("fi_done", done, 1);
    check_eq("fi_inv_drop", ic_inv_req, 0);
    step();
    check_eq("fi_after", {flush_valid, done, busy, ic_inv_req}, 0);
    check_eq("fi_after_pc", flush_pc, 0);

    // FENCE.I at top of address space with ack already high.
    ic_inv_ack = 1'b1;
    send(fk_fence_i, 32'hFFFF_FFFC);
    check_eq("fw_drain_inv", ic_inv_req, 0);
    step();
    check_eq("fw_inv_req", ic_inv_req, 1);
    step();
    ic_inv_ack = 1'b0;
    check_eq("fw_flush_valid", flush_valid, 1);
    check_eq("fw_flush_pc", flush_pc, 32'h0000_0000);
    check_eq("fw_inv_drop", ic_inv_req, 0);
    step();
    check_eq("fw_idle", busy, 0);

    // Invalid kind.
    send(fk_invalid, 32'h0000_0200);
    check_eq("inv_illegal", illegal, 1);
    check_eq("inv_busy", busy, 0);
    check_eq("inv_done", done, 0);
    step();
    check_eq("inv_pulse_end", illegal, 0);
    check_eq("inv_no_done", done, 0);

    // Counter saturation and sticky overflow.
    mem_issue = 1'b1;
    repeat (15) step();
    check_eq("ovf_count15", dut.count_q, 15);
    check_eq("ovf_clear", overflow, 0);
    step();
    mem_issue = 1'b0;
    check_eq("ovf_hold", dut.count_q, 15);
    check_eq("ovf_set", overflow, 1);
    mem_complete = 1'b1;
    repeat (16) step();
    mem_complete = 1'b0;
    check_eq("under_hold", dut.count_q, 0);
    check_eq("ovf_sticky", overflow, 1);

    // Reset asserted mid-invalidate.
    send(fk_fence_i, 32'h0000_3000);
    step();
    mem_issue = 1'b1;
    repeat (2) step();
    mem_issue = 1'b0;
    check_eq("rinv_req", ic_inv_req, 1);
    check_eq("rinv_count", dut.count_q, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rinv_req_drop", ic_inv_req, 0);
    check_eq("rinv_busy", busy, 0);
    check_eq("rinv_count0", dut.count_q, 0);
    check_eq("rinv_ovf", overflow, 0);
    check_eq("rinv_ready", req_if.req_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    send(fk_fence, 32'h0000_4000);
    check_eq("rinv_next_busy", busy, 1);
    step();
    check_eq("rinv_next_done", done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
